// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer: streams 32-bit limbs through one cla_32bit, LSB limb first.
// Optional signed-overflow flag is built only when CLA_SEQ_OVF_EN is defined.

module cla_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_start,
    output logic [31:0] sum,
    output logic        carry_out
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;

    assign g = a & b;
    assign p = a ^ b;

    // Full lookahead inside each nibble; nibble carries chain through group generate/propagate.
    always_comb begin
        grp_g    = '0;
        grp_p    = '0;
        grp_c    = '0;
        grp_c[0] = carry_start;
        for (int j = 0; j < 8; j++) begin
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
    end

    always_comb begin
        c = '0;
        for (int j = 0; j < 8; j++) begin
            c[4*j]   = grp_c[j];
            c[4*j+1] = g[4*j] | (p[4*j] & grp_c[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & grp_c[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & grp_c[j]);
        end
    end

    assign sum       = p ^ c;
    assign carry_out = grp_c[8];

endmodule

module cla_mp_seq #(
    parameter int WORDS = 4,
    parameter int IW    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam int            MSB      = 32*WORDS-1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS-1);

    logic [0:0]          state;
    logic [IW-1:0]       idx;
    logic                carry_reg;
    logic [32*WORDS-1:0] a_lat;
    logic [32*WORDS-1:0] b_lat;
    logic [31:0]         a_limb;
    logic [31:0]         b_limb;
    logic [31:0]         limb_sum;
    logic                limb_carry;

    // b_lat already holds ~b for subtraction, so the adder only ever adds.
    assign a_limb = a_lat[{idx, 5'd0} +: 32];
    assign b_limb = b_lat[{idx, 5'd0} +: 32];
    assign busy   = (state == ST_RUN);

    cla_32bit u_cla (
        .a           (a_limb),
        .b           (b_limb),
        .carry_start (carry_reg),
        .sum         (limb_sum),
        .carry_out   (limb_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_lat     <= a;
                        b_lat     <= sub ? ~b : b;
                        carry_reg <= sub;
                        idx       <= '0;
                        state     <= ST_RUN;
                    end
                end
                default: begin
                    result[{idx, 5'd0} +: 32] <= limb_sum;
                    carry_reg                 <= limb_carry;
                    if (idx == LAST_IDX) begin
                        state     <= ST_IDLE;
                        done      <= 1'b1;
                        carry_out <= limb_carry;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef CLA_SEQ_OVF_EN
    // Signed overflow: both operands disagree in sign with the final sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            overflow <= 1'b0;
        end else if (state == ST_RUN && idx == LAST_IDX) begin
            overflow <= (a_lat[MSB] ^ limb_sum[31]) & (b_lat[MSB] ^ limb_sum[31]);
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cla_mp_seq.sv
// Scoreboard bench for cla_mp_seq (WORDS=4): stimulus pushes expectations, a monitor checks on done.

module tb_cla_mp_seq;

    localparam int WORDS = 4;
    localparam int IW    = 2;
    localparam int W     = 32*WORDS;

`ifdef CLA_SEQ_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cla_mp_seq #(.WORDS(WORDS), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one request at a negedge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W-1:0] er, input logic ec, input logic eo,
                                 input string name);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = av;
        b     = bv;
        e.res  = er;
        e.c    = ec;
        e.o    = eo;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_done_seen"}, W'(seen), W'(1));
    endtask

    // Monitor: one pop per done pulse; a done with nothing queued is an error.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spurious_done actual=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_result"}, result, e.res);
                    checkOutput({e.name, "_carry"}, W'(carry_out), W'(e.c));
                    checkOutput({e.name, "_ovf"}, W'(overflow), W'(e.o));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_cnt;
        int done_at;
        int done_cnt;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", W'(busy), '0);
        checkOutput("rst_done", W'(done), '0);
        checkOutput("rst_result", result, '0);
        checkOutput("rst_carry", W'(carry_out), '0);
        checkOutput("rst_ovf", W'(overflow), '0);
        rst_n = 1'b1;

        $display("[TB] test 1: all-ones + 1 with latency");
        applyStimulus(1'b0, {W{1'b1}}, W'(1), '0, 1'b1, 1'b0, "t1");
        busy_cnt = 0;
        done_at  = -1;
        for (int n = 0; n < 20; n++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_at = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("t1_done_latency", W'(done_at), W'(WORDS));
        checkOutput("t1_busy_cycles", W'(busy_cnt), W'(WORDS));

        $display("[TB] test 2: subtraction with and without borrow");
        applyStimulus(1'b1, W'(5), W'(7), {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0, "t2a");
        waitDone("t2a");
        applyStimulus(1'b1, W'(7), W'(5), W'(2), 1'b1, 1'b0, "t2b");
        waitDone("t2b");

        $display("[TB] test 3: inter-limb carry");
        applyStimulus(1'b0, W'(32'hFFFF_FFFF), W'(1), W'(64'h1_0000_0000), 1'b0, 1'b0, "t3");
        waitDone("t3");

        $display("[TB] test 4: start while busy, start in done cycle");
        applyStimulus(1'b0, W'(3), W'(4), W'(7), 1'b0, 1'b0, "t4a");
        @(posedge clk);
        #1;
        start = 1'b1;
        sub   = 1'b1;
        a     = {W{1'b1}};
        b     = W'(12345);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("t4_done_at_k4", W'(done), W'(1));
        applyStimulus(1'b1, W'(100), W'(1), W'(99), 1'b1, 1'b0, "t4b");
        checkOutput("t4_busy_on_accept", W'(busy), W'(1));
        checkOutput("t4_done_dropped", W'(done), '0);
        waitDone("t4b");

        $display("[TB] test 5: reset mid-run");
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        a     = W'(9);
        b     = W'(9);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_busy", W'(busy), '0);
        checkOutput("t5_done", W'(done), '0);
        checkOutput("t5_result", result, '0);
        checkOutput("t5_carry", W'(carry_out), '0);
        checkOutput("t5_ovf", W'(overflow), '0);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        checkOutput("t5_no_done", W'(done_cnt), '0);

        $display("[TB] test 6: signed overflow");
        applyStimulus(1'b0, {1'b0, {(W-1){1'b1}}}, W'(1), {1'b1, {(W-1){1'b0}}}, 1'b0, OVF_ON, "t6a");
        waitDone("t6a");
        applyStimulus(1'b1, '0, W'(1), {W{1'b1}}, 1'b0, 1'b0, "t6b");
        checkOutput("t6_ovf_cleared", W'(overflow), '0);
        waitDone("t6b");

        for (int n = 0; n < 10; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        checkOutput("sb_drained", W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
